alu_arbiter: RTL and testbench

//   Shares the single registered ALU between NREQ requesters (e.g. execute stage, branch compare, address gen).

---
 rtl/alu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between NREQ requesters,
// with a per-op watchdog that aborts an op whose ALU result never arrives.
module alu_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OPW     = 5,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*OPW-1:0]   req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  alu_en,
  output logic [OPW-1:0]        alu_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic                  alu_valid,
  input  logic [WIDTH-1:0]      alu_data
);

  localparam int unsigned IDXW = $clog2(NREQ);
  localparam int unsigned WDW  = $clog2(TIMEOUT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;
  logic            alu_en_q, alu_en_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;

  logic            win_found;
  logic [IDXW-1:0] win_idx;
  int unsigned     cand;

  // Scan from the requester just after the last owner, wrapping, so the
  // previous winner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(ptr_q) + k) % NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDXW'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    wdog_d      = wdog_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    alu_en_d    = 1'b0;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;

    case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d[win_idx] = 1'b1;
          owner_d        = win_idx;
          alu_op_d       = req_op[win_idx*OPW +: OPW];
          alu_a_d        = req_a[win_idx*WIDTH +: WIDTH];
          alu_b_d        = req_b[win_idx*WIDTH +: WIDTH];
          // Registered enable: high exactly during the ISSUE cycle.
          alu_en_d       = 1'b1;
          state_d        = StIssue;
        end
      end
      StIssue: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (alu_valid) begin
          rsp_data_d           = alu_data;
          rsp_err_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          ptr_d                = owner_q;
          state_d              = StIdle;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          rsp_data_d           = '0;
          rsp_err_d            = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          ptr_d                = owner_q;
          state_d              = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= IDXW'(NREQ - 1);
      owner_q     <= '0;
      wdog_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wdog_q      <= wdog_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      alu_en_q    <= alu_en_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign alu_en    = alu_en_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: 1-cycle ALU model, response scoreboard,
// immediate-assertion checks.
module tb_alu_arbiter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned OPW     = 5;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned TIMEOUT = 8;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*OPW-1:0]   req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic                  busy;
  logic                  alu_en;
  logic [OPW-1:0]        alu_op;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic                  alu_valid;
  logic [WIDTH-1:0]      alu_data;

  alu_arbiter #(
    .WIDTH  (WIDTH),
    .OPW    (OPW),
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .alu_en   (alu_en),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_valid(alu_valid),
    .alu_data (alu_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: mode 0 answers one cycle after alu_en, mode 1 never answers.
  int          mode;
  logic        en_d1;
  logic [31:0] res_q;
  logic        inject_valid;
  logic [31:0] inject_data;

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    en_d1 <= rst ? 1'b0 : alu_en;
    if (alu_en) res_q <= alu_f(alu_op, alu_a, alu_b);
  end

  assign alu_valid = ((mode == 0) && en_d1) || inject_valid;
  assign alu_data  = inject_valid ? inject_data : res_q;

  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[i*OPW +: OPW]     = op;
    req_a[i*WIDTH +: WIDTH]  = a;
    req_b[i*WIDTH +: WIDTH]  = b;
  endtask

  task automatic wait_gnt(input string tag, input int budget, output int at);
    int n;
    n = 0;
    while (gnt == '0 && n < budget) begin
      step();
      n++;
    end
    at = cyc;
    if (gnt == '0) begin
      checks++;
      errors++;
      $error("FAIL %s no gnt within %0d cycles", tag, budget);
    end
  endtask

  // Waits for rsp_valid, pops the scoreboard and compares; exp_lat < 0 skips latency.
  task automatic wait_rsp(input string tag, input int budget, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    while (rsp_valid == '0 && n < budget) begin
      step();
      n++;
    end
    if (rsp_valid == '0) begin
      checks++;
      errors++;
      $error("FAIL %s no rsp_valid within %0d cycles", tag, budget);
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s unexpected rsp_valid %0h", tag, rsp_valid);
    end else begin
      e = sb.pop_front();
      check({tag, "_vld"}, 64'(rsp_valid), 64'(e.vld));
      check({tag, "_data"}, 64'(rsp_data), 64'(e.data));
      check({tag, "_err"}, 64'(rsp_err), 64'(e.err));
      if (exp_lat >= 0) check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'd0);
    check({tag, "_rspv"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rspd"}, 64'(rsp_data), 64'd0);
    check({tag, "_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_en"}, 64'(alu_en), 64'd0);
    check({tag, "_op"}, 64'(alu_op), 64'd0);
    check({tag, "_a"}, 64'(alu_a), 64'd0);
    check({tag, "_b"}, 64'(alu_b), 64'd0);
  endtask

  initial begin
    int g;
    int g_prev;
    logic [1:0] order [4];
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    mode         = 0;
    inject_valid = 1'b0;
    inject_data  = '0;
    rst          = 1'b1;
    req          = '0;
    req_op       = '0;
    req_a        = '0;
    req_b        = '0;
    step();
    step();
    check_idle_zero("reset");

    // Single op: 7 + 5 from requester 0.
    rst = 1'b0;
    req = 2'b01;
    set_req(0, 5'd1, 32'd7, 32'd5);
    sb.push_back('{vld: 2'b01, data: 32'd12, err: 1'b0});
    step();
    check("t1_gnt", 64'(gnt), 64'h1);
    check("t1_en", 64'(alu_en), 64'h1);
    check("t1_busy", 64'(busy), 64'h1);
    check("t1_a", 64'(alu_a), 64'd7);
    check("t1_b", 64'(alu_b), 64'd5);
    req = '0;
    step();
    check("t1_gnt_pulse", 64'(gnt), 64'h0);
    check("t1_en_pulse", 64'(alu_en), 64'h0);
    wait_rsp("t1", 4, 1);

    // Contention from a fresh reset: grant order 0,1,0,1 spaced 3 cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 5'd1, 32'd10, 32'd3);
    set_req(1, 5'd2, 32'd50, 32'd8);
    req = 2'b11;
    order[0] = 2'b01;
    order[1] = 2'b10;
    order[2] = 2'b01;
    order[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{vld: order[i], data: (order[i] == 2'b01) ? 32'd13 : 32'd42, err: 1'b0});
    end
    g_prev = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      wait_gnt("t2_gnt", 6, g);
      check("t2_order", 64'(gnt), 64'(order[i]));
      if (i > 0) check("t2_spacing", 64'(g - g_prev), 64'd3);
      g_prev = g;
      if (i == 3) req = '0;
      wait_rsp("t2", 4, 2);
    end

    // Watchdog abort from requester 1, then a normal op from requester 0.
    mode = 1;
    req  = 2'b10;
    set_req(1, 5'd1, 32'd1, 32'd1);
    sb.push_back('{vld: 2'b10, data: 32'd0, err: 1'b1});
    step();
    check("t3_gnt", 64'(gnt), 64'h2);
    req = '0;
    wait_rsp("t3", 16, TIMEOUT + 1);
    check("t3_busy", 64'(busy), 64'h0);
    mode = 0;
    req  = 2'b01;
    set_req(0, 5'd3, 32'hF0, 32'h0F);
    sb.push_back('{vld: 2'b01, data: 32'hFF, err: 1'b0});
    step();
    check("t3_next_gnt", 64'(gnt), 64'h1);
    req = '0;
    wait_rsp("t3_next", 4, 2);

    // alu_valid arriving on the last watchdog cycle wins over the abort.
    mode = 1;
    req  = 2'b01;
    set_req(0, 5'd1, 32'd2, 32'd2);
    sb.push_back('{vld: 2'b01, data: 32'hDEAD_BEEF, err: 1'b0});
    step();
    check("t4_gnt", 64'(gnt), 64'h1);
    req = '0;
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      check("t4_no_rsp", 64'(rsp_valid), 64'h0);
    end
    inject_valid = 1'b1;
    inject_data  = 32'hDEAD_BEEF;
    wait_rsp("t4", 2, 1);
    inject_valid = 1'b0;

    // Reset during WAIT discards the op; requester 0 wins first afterwards.
    req = 2'b01;
    set_req(0, 5'd1, 32'd3, 32'd3);
    step();
    check("t5_gnt", 64'(gnt), 64'h1);
    req = '0;
    step();
    step();
    check("t5_busy_wait", 64'(busy), 64'h1);
    rst = 1'b1;
    step();
    check_idle_zero("t5_rst");
    rst  = 1'b0;
    mode = 0;
    set_req(0, 5'd1, 32'd100, 32'd23);
    set_req(1, 5'd2, 32'd9, 32'd4);
    req = 2'b11;
    sb.push_back('{vld: 2'b01, data: 32'd123, err: 1'b0});
    step();
    check("t5_first_gnt", 64'(gnt), 64'h1);
    req = '0;
    wait_rsp("t5", 4, 2);

    // Spurious alu_valid while idle is ignored.
    inject_valid = 1'b1;
    inject_data  = 32'd99;
    step();
    inject_valid = 1'b0;
    check("t6_rspv", 64'(rsp_valid), 64'h0);
    check("t6_rspd", 64'(rsp_data), 64'd123);
    check("t6_busy", 64'(busy), 64'h0);
    step();
    check("t6_rspv2", 64'(rsp_valid), 64'h0);
    check("t6_rspd2", 64'(rsp_data), 64'd123);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
